la_capture_controller: RTL
==========================

Name: la_capture_controller

Overview:
- Parametrised capture-sequencing FSM for the logic analyzer core.
- Sits between the trigger block (consumes its trig_i) and the sample memory (drives its write pointer and write enable).
- Register-mapped on the daisy-chained addr/wdata/rdata/rw/valid bus.
- Adds three trigger modes (single-event, incremental, immediate), explicit start/stop requests, a clamped trigger location and ring-buffer pre-trigger capture for any SAMPLE_DEPTH.

Parameters:
- BASE_ADDR, 0, first bus address of the register block.
- SAMPLE_DEPTH, 1024, sample memory depth in entries; power of two, at least 4.
- ADDR_WIDTH, $clog2(SAMPLE_DEPTH), pointer width; derived, never overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- trig_i  in  1  trigger condition from the trigger block, evaluated each cycle.
- addr_i / wdata_i / rdata_i  in  16 each  bus input.
- rw_i  in  1  1 = write, 0 = read.
- valid_i  in  1  bus transaction strobe.
- addr_o / wdata_o / rdata_o  out  16 each  bus output.
- rw_o / valid_o  out  1 each  bus output.
- write_pointer_o  out  ADDR_WIDTH  sample memory write address.
- write_enable_o  out  1  sample memory writes the probe word at write_pointer_o on this edge.

Behaviour:
Reset:
- Async clear: state = IDLE, mode = SINGLE_EVENT, trigger_loc = 0, both pointers = 0, all bus outputs = 0, write_enable_o = 0.
- Reset mid-capture aborts immediately; no partial state survives.

Bus:
- One-cycle pipeline: every *_o registers its *_i each cycle.
- If valid_i and addr_i is in BASE_ADDR..BASE_ADDR+6:
  - Read: rdata_o takes the register value, zero-extended.
  - Write: updates the register; rdata_o passes through unchanged.
- Out-of-range addresses pass through untouched.
- Register map (offset, name, access):
  - 0 state, RO.
  - 1 trigger_mode, RW, 2 bits.
  - 2 trigger_loc, RW.
  - 3 request_start, WO, reads 0.
  - 4 request_stop, WO, reads 0.
  - 5 read_pointer, RO.
  - 6 write_pointer, RO.
- Writes to RO registers are ignored.
- trigger_mode and trigger_loc writes apply only in IDLE or CAPTURED; otherwise they are ignored.
- trigger_loc writes of SAMPLE_DEPTH or more clamp to SAMPLE_DEPTH-1.
- trigger_mode value 3 is stored as IMMEDIATE.

States: IDLE=0, MOVE_TO_POSITION=1, IN_POSITION=2, CAPTURING=3, CAPTURED=4.
- request_start (write with wdata bit0 = 1):
  - Accepted only in IDLE or CAPTURED; ignored otherwise.
  - Clears both pointers, then branches on mode:
    - SINGLE_EVENT: go to MOVE_TO_POSITION, or IN_POSITION if trigger_loc = 0.
    - IMMEDIATE or INCREMENTAL: go to CAPTURING.
- request_stop (bit0 = 1): any state goes to IDLE next cycle; pointers hold; write_enable_o = 0 from that cycle.
- MOVE_TO_POSITION:
  - Writes every cycle; write_pointer increments.
  - trig_i is ignored (insufficient pre-trigger history).
  - In the cycle write_pointer = trigger_loc-1, go to IN_POSITION.
- IN_POSITION:
  - Writes every cycle; both pointers increment modulo SAMPLE_DEPTH (ring).
  - The gap write_pointer - read_pointer = trigger_loc is maintained.
  - When trig_i = 1, this cycle's sample is written, read_pointer holds, and the FSM goes to CAPTURING.
- CAPTURING:
  - Each write increments write_pointer.
  - After the write at write_pointer = read_pointer-1 (mod depth), go to CAPTURED.
  - Exactly SAMPLE_DEPTH samples are then valid, starting at read_pointer.
  - The trigger sample sits at read_pointer + trigger_loc.
- Mode differences:
  - IMMEDIATE: writes every cycle, ignores trig_i and trigger_loc; read_pointer = 0.
  - INCREMENTAL: writes only on cycles with trig_i = 1; ends after SAMPLE_DEPTH qualified samples.
- CAPTURED: write_enable_o = 0; pointers hold for readout.
- write_enable_o is combinational: state in {1,2,3} and (mode != INCREMENTAL or trig_i).
- write_pointer_o equals the write_pointer register.
- Pointer arithmetic is ADDR_WIDTH bits and wraps naturally.

Decomposition:
- Package la_capture_pkg holds:
  - state enum;
  - trigger_mode enum (SINGLE_EVENT=0, INCREMENTAL=1, IMMEDIATE=2);
  - register offset constants.
- Sub-module la_capture_regs holds bus decode, the pipeline registers and the start/stop strobes; the FSM and pointers stay in the top.

Test Plan (SAMPLE_DEPTH=16, BASE_ADDR=0):
- Reset and register access: assert rst_n = 0 mid-CAPTURING -> state 0, pointers 0, bus outputs 0. Then write trigger_loc = 5 and read back 5; write trigger_loc = 40 -> reads 15; write state -> still reads 0.
- SINGLE_EVENT pre-trigger: trigger_loc = 4, start, hold trig_i = 0 for 20 cycles -> state 2 with write_pointer - read_pointer = 4. Pulse trig_i -> CAPTURED after exactly 12 further writes, write_pointer_o = read_pointer-1, 16 writes total from the trigger window.
- Early trigger ignored: trigger_loc = 6, trig_i = 1 from the start cycle -> stays MOVE_TO_POSITION for 6 writes, then triggers on the first IN_POSITION cycle.
- IMMEDIATE: mode = 2, start -> write_enable_o = 1 for exactly 16 consecutive cycles with pointers 0..15, then state 4, read_pointer 0.
- INCREMENTAL: mode = 1, trig_i toggling every other cycle -> write_enable_o follows trig_i; CAPTURED after 16 qualified samples (about 32 cycles).
- Stop and guard: request_stop in IN_POSITION -> IDLE next cycle, write_enable_o = 0, pointers held. Writes to trigger_loc or mode while CAPTURING are ignored. request_start while CAPTURING is ignored.

Source files
------------

// File: rtl/la_capture_controller_pkg.sv
// Shared types and register map for the logic-analyzer capture controller.
// The FSM, its register block and the testbench import these definitions.
package la_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE             = 3'd0,
        ST_MOVE_TO_POSITION = 3'd1,
        ST_IN_POSITION      = 3'd2,
        ST_CAPTURING        = 3'd3,
        ST_CAPTURED         = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_SINGLE_EVENT = 2'd0,
        MODE_INCREMENTAL  = 2'd1,
        MODE_IMMEDIATE    = 2'd2
    } trig_mode_e;

    localparam logic [15:0] REG_STATE         = 16'd0;
    localparam logic [15:0] REG_TRIGGER_MODE  = 16'd1;
    localparam logic [15:0] REG_TRIGGER_LOC   = 16'd2;
    localparam logic [15:0] REG_REQUEST_START = 16'd3;
    localparam logic [15:0] REG_REQUEST_STOP  = 16'd4;
    localparam logic [15:0] REG_READ_POINTER  = 16'd5;
    localparam logic [15:0] REG_WRITE_POINTER = 16'd6;
    localparam logic [15:0] NUM_REGS          = 16'd7;

    // The unused encoding 3 behaves as IMMEDIATE.
    function automatic trig_mode_e decode_mode(input logic [1:0] v);
        return (v == 2'd3) ? MODE_IMMEDIATE : trig_mode_e'(v);
    endfunction

endpackage

// File: rtl/la_capture_controller_if.sv
// Daisy-chained register bus: valid qualifies addr/wdata/rw for one cycle; there is
// no ready, so every transaction is accepted and forwarded one cycle later.
interface la_capture_bus_if;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rw;
    logic        valid;

    modport master (output addr, wdata, rdata, rw, valid);
    modport slave  (input  addr, wdata, rdata, rw, valid);
endinterface

// File: rtl/la_capture_controller_regs.sv
// Bus decode for the capture controller: pipeline registers, mode/trigger_loc
// storage and the start/stop request strobes consumed by the FSM.
module la_capture_regs
    import la_capture_pkg::*;
#(
    parameter int unsigned BASE_ADDR    = 0,
    parameter int          SAMPLE_DEPTH = 1024,
    parameter int          ADDR_WIDTH   = $clog2(SAMPLE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    la_capture_bus_if.slave       bus_i,
    la_capture_bus_if.master      bus_o,
    input  state_e                state_i,
    input  logic [ADDR_WIDTH-1:0] read_pointer_i,
    input  logic [ADDR_WIDTH-1:0] write_pointer_i,
    output trig_mode_e            mode_o,
    output logic [ADDR_WIDTH-1:0] trigger_loc_o,
    output logic                  start_o,
    output logic                  stop_o
);

    localparam logic [16:0]           BASE17  = 17'(BASE_ADDR);
    localparam logic [16:0]           DEPTH17 = 17'(SAMPLE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LOC_MAX = ADDR_WIDTH'(SAMPLE_DEPTH - 1);

    logic [16:0]           rel;
    logic [15:0]           offset;
    logic                  hit, wr_hit, cfg_open;
    logic [15:0]           rd_val;
    trig_mode_e            mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] loc_q, loc_d;
    logic [15:0]           addr_q, wdata_q, rdata_q, rdata_d;
    logic                  rw_q, valid_q;

    // A borrow out of the 17-bit subtraction means the address lies below the block.
    assign rel      = {1'b0, bus_i.addr} - BASE17;
    assign offset   = rel[15:0];
    assign hit      = bus_i.valid && !rel[16] && (offset < NUM_REGS);
    assign wr_hit   = hit && bus_i.rw;
    assign cfg_open = (state_i == ST_IDLE) || (state_i == ST_CAPTURED);
    assign start_o  = wr_hit && (offset == REG_REQUEST_START) && bus_i.wdata[0];
    assign stop_o   = wr_hit && (offset == REG_REQUEST_STOP) && bus_i.wdata[0];

    always_comb begin
        rd_val = '0;
        case (offset)
            REG_STATE:         rd_val = 16'(state_i);
            REG_TRIGGER_MODE:  rd_val = 16'(mode_q);
            REG_TRIGGER_LOC:   rd_val = 16'(loc_q);
            REG_READ_POINTER:  rd_val = 16'(read_pointer_i);
            REG_WRITE_POINTER: rd_val = 16'(write_pointer_i);
            default:           rd_val = '0;
        endcase
    end

    always_comb begin
        mode_d  = mode_q;
        loc_d   = loc_q;
        rdata_d = bus_i.rdata;
        if (hit && !bus_i.rw) rdata_d = rd_val;
        // Configuration is frozen while a capture is in flight.
        if (wr_hit && cfg_open) begin
            if (offset == REG_TRIGGER_MODE) mode_d = decode_mode(bus_i.wdata[1:0]);
            if (offset == REG_TRIGGER_LOC)
                loc_d = ({1'b0, bus_i.wdata} >= DEPTH17) ? LOC_MAX : bus_i.wdata[ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_SINGLE_EVENT;
            loc_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            loc_q   <= loc_d;
            addr_q  <= bus_i.addr;
            wdata_q <= bus_i.wdata;
            rdata_q <= rdata_d;
            rw_q    <= bus_i.rw;
            valid_q <= bus_i.valid;
        end
    end

    assign bus_o.addr    = addr_q;
    assign bus_o.wdata   = wdata_q;
    assign bus_o.rdata   = rdata_q;
    assign bus_o.rw      = rw_q;
    assign bus_o.valid   = valid_q;
    assign mode_o        = mode_q;
    assign trigger_loc_o = loc_q;

endmodule

// File: rtl/la_capture_controller.sv
// Capture-sequencing FSM: fills the sample memory as a ring around the trigger
// point and leaves SAMPLE_DEPTH valid samples starting at read_pointer.
module la_capture_controller
    import la_capture_pkg::*;
#(
    parameter int unsigned BASE_ADDR    = 0,
    parameter int          SAMPLE_DEPTH = 1024,
    parameter int          ADDR_WIDTH   = $clog2(SAMPLE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trig_i,
    la_capture_bus_if.slave       bus_i,
    la_capture_bus_if.master      bus_o,
    output logic [ADDR_WIDTH-1:0] write_pointer_o,
    output logic                  write_enable_o,
    output logic [2:0]            dbg_state_o
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [ADDR_WIDTH-1:0] rp_m1, trigger_loc;
    trig_mode_e            mode;
    logic                  start_req, stop_req, cfg_open, last_slot;

    la_capture_regs #(
        .BASE_ADDR    (BASE_ADDR),
        .SAMPLE_DEPTH (SAMPLE_DEPTH),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_regs (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus_i           (bus_i),
        .bus_o           (bus_o),
        .state_i         (state_q),
        .read_pointer_i  (rp_q),
        .write_pointer_i (wp_q),
        .mode_o          (mode),
        .trigger_loc_o   (trigger_loc),
        .start_o         (start_req),
        .stop_o          (stop_req)
    );

    assign cfg_open  = (state_q == ST_IDLE) || (state_q == ST_CAPTURED);
    assign rp_m1     = rp_q - PTR_ONE;
    // The slot just behind read_pointer is the last one of the ring.
    assign last_slot = (wp_q == rp_m1);

    assign write_enable_o = ((state_q == ST_MOVE_TO_POSITION) || (state_q == ST_IN_POSITION) ||
                             (state_q == ST_CAPTURING)) && ((mode != MODE_INCREMENTAL) || trig_i);

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        if (stop_req) begin
            state_d = ST_IDLE;
        end else if (start_req && cfg_open) begin
            wp_d = '0;
            rp_d = '0;
            if (mode == MODE_SINGLE_EVENT)
                state_d = (trigger_loc == '0) ? ST_IN_POSITION : ST_MOVE_TO_POSITION;
            else
                state_d = ST_CAPTURING;
        end else begin
            case (state_q)
                ST_MOVE_TO_POSITION: begin
                    wp_d = wp_q + PTR_ONE;
                    if (wp_q == trigger_loc - PTR_ONE) state_d = ST_IN_POSITION;
                end
                ST_IN_POSITION: begin
                    if (trig_i) begin
                        // With trigger_loc = SAMPLE_DEPTH-1 the trigger sample completes the ring.
                        if (last_slot) begin
                            state_d = ST_CAPTURED;
                        end else begin
                            wp_d    = wp_q + PTR_ONE;
                            state_d = ST_CAPTURING;
                        end
                    end else begin
                        wp_d = wp_q + PTR_ONE;
                        rp_d = rp_q + PTR_ONE;
                    end
                end
                ST_CAPTURING: begin
                    if (write_enable_o) begin
                        if (last_slot) state_d = ST_CAPTURED;
                        else           wp_d    = wp_q + PTR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
        end
    end

    assign write_pointer_o = wp_q;
    assign dbg_state_o     = state_q;

endmodule
